alu_muldiv_seq: RTL
===================

# alu_muldiv_seq

Multi-cycle sequencer that computes 32-bit MUL (low word), DIVU and REMU by driving the shared combinational ALU one operation per cycle. It owns the ALU operand/opcode inputs while busy and reads the ALU result back in the same cycle. It sits beside the execute stage and exchanges requests and results with it over valid/ready handshakes.

## Interface

- No parameters. Widths are fixed at 32 bits, matching the ALU.
- i_clk  input  1  clock; all state changes on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  request accepted when i_valid & o_ready at a rising edge; = (state==IDLE) & ~i_reset
- i_op  input  2  0 MUL, 1 DIVU, 2 REMU, 3 treated as MUL
- i_src_a  input  32  multiplicand / dividend
- i_src_b  input  32  multiplier / divisor
- o_valid  output  1  result valid; registered
- i_ready  input  1  result consumed when o_valid & i_ready at a rising edge
- o_result  output  32  result; held stable while o_valid=1
- o_busy  output  1  1 in any state other than IDLE
- o_alu_op  output  4  ALU opcode: ADD=0000, SUB=0001, SLTU=0011
- o_operand_a  output  32  ALU operand A
- o_operand_b  output  32  ALU operand B
- i_alu_data  input  32  ALU result, combinational from o_* in the same cycle

## Operation

- Registers: acc/rem R[31:0], mcand/divisor D[31:0], mplier/quotient Q[31:0], cnt[4:0], op, lt flag, state.
- States: IDLE, MUL_IT, DIV_CMP, DIV_SUB, DONE.
- IDLE, on accept:
  - latch op.
  - R=0, D=i_src_b (DIV) or i_src_a (MUL), Q=i_src_a (DIV) or i_src_b (MUL), cnt=0.
  - next state: MUL_IT for ops 0/3, DIV_CMP for ops 1/2.
- MUL_IT, each cycle:
  - ALU inputs: op=ADD, a=R, b = Q[0] ? D : 0.
  - R<=i_alu_data; D<=D<<1; Q<=Q>>1; cnt++.
  - After cnt==31: result=R (low 32 bits, sign-agnostic), go to DONE.
- DIV_CMP:
  - Form R' = {R[30:0],Q[31]}.
  - ALU inputs: op=SLTU, a=R', b=D.
  - R<=R'; Q<=Q<<1; lt <= i_alu_data[0] & ~R[31]. R[31] is taken before the shift; if it is 1, R' is at least 2^32, which exceeds D, so a subtract is forced.
  - Go to DIV_SUB.
- DIV_SUB:
  - ALU inputs: op=SUB, a=R, b=D (always driven).
  - If ~lt: R<=i_alu_data (mod 2^32), Q[0]<=1. Else R and Q unchanged.
  - cnt++. After cnt==31: result = Q (DIVU) or R (REMU), go to DONE; else return to DIV_CMP.
- Divide by zero needs no special case; the algorithm yields DIVU=0xFFFFFFFF and REMU=dividend. Latency is fixed: no early exit and no zero-skip.
- DONE:
  - o_valid=1, o_result registered.
  - On i_ready go to IDLE and clear o_valid.
  - o_result keeps its value after the handshake.
- ALU ports in IDLE/DONE: op=ADD, operands 0.
- i_valid while not in IDLE is ignored; no queuing.
- i_src_a, i_src_b and i_op are sampled only at accept. Changes afterwards have no effect.

## Timing

- Reset (synchronous, i_reset=1 at an edge):
  - state=IDLE, o_valid=0, o_result=0, R/D/Q/cnt/lt=0.
  - o_ready=0 during the reset cycle, 1 in the cycle after.
- Reset mid-operation aborts with no o_valid pulse.
- Reset overrides a simultaneous accept or result handshake.
- Accept at edge E:
  - MUL: o_valid is first high after edge E+32 (32 MUL_IT cycles).
  - DIV: o_valid is first high after edge E+64 (32 CMP/SUB pairs).
- Result handshake at edge F: o_ready is high after F, so the next accept is at F+1 at the earliest. Minimum issue interval is 34 cycles for MUL and 66 for DIV when i_ready is held at 1.
- Backpressure: o_valid and o_result hold indefinitely while i_ready=0.
- ALU usage: exactly one ALU op per busy cycle. i_alu_data is consumed in the same cycle and never registered inside the ALU.

## Test plan

- MUL 7×6 with i_ready=1 → o_result=42; o_valid rises 32 edges after accept and is high for exactly 1 cycle; o_busy is high for 33 cycles.
- MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. Also MUL 0x80000000×2 → 0x00000000, and op=3 with 3×5 → 15.
- DIVU 100/7 → 14, REMU 100/7 → 2, each 64 edges after accept. DIVU 0xFFFFFFFF/0xFFFFFFFE → 1 and REMU of the same operands → 1, which exercises the forced subtract on R[31].
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, latency unchanged at 64.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid and toggle i_valid/i_src_* meanwhile → o_result stable, no new accept, o_ready=0. Release → next request accepted one cycle after the handshake.
- Reset mid-op: assert i_reset at cycle 20 of a DIVU → o_valid never rises, and o_ready=1 one cycle after reset deasserts. A subsequent MUL 3×4 → 12 with normal latency.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: request/result handshake between the execute stage
// (master) and the multi-cycle MUL/DIVU/REMU sequencer (slave).
//   i_valid/o_ready            request handshake
//   i_op, i_src_a, i_src_b     request payload (sampled at accept only)
//   o_valid/i_ready            result handshake
//   o_result                   result word, held while o_valid=1
//   o_busy                     sequencer is not idle
`timescale 1ns/1ps
interface alu_muldiv_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_src_a;
  logic [31:0] i_src_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  modport master (
    output i_valid, i_op, i_src_a, i_src_b, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_src_a, i_src_b, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: computes MUL (low word), DIVU and REMU on 32-bit operands
// by issuing one operation per cycle to the shared combinational ALU.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   bus              request/result handshake (slave side)
//   o_alu_op         ALU opcode (ADD=0000, SUB=0001, SLTU=0011)
//   o_operand_a/b    ALU operands
//   i_alu_data       ALU result, combinational from the outputs above
// MUL takes 32 shift-add cycles; DIV takes 32 compare/subtract pairs.
`timescale 1ns/1ps
module alu_muldiv_seq (
  input  logic                    i_clk,
  input  logic                    i_reset,
  alu_muldiv_seq_if.slave         bus,
  output logic [3:0]              o_alu_op,
  output logic [31:0]             o_operand_a,
  output logic [31:0]             o_operand_b,
  input  logic [31:0]             i_alu_data
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_IT  = 3'd1,
    ST_DIV_CMP = 3'd2,
    ST_DIV_SUB = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] rem_r;     // MUL accumulator / DIV partial remainder
  logic [31:0] dsr_r;     // MUL multiplicand / DIV divisor
  logic [31:0] quo_r;     // MUL multiplier / DIV dividend-then-quotient
  logic [31:0] result_r;
  logic [4:0]  cnt_r;
  logic [1:0]  op_r;
  logic        lt_r;
  logic        valid_r;
  logic        req_is_div_s;
  logic        last_s;
  logic [31:0] rem_shift_s;

  assign req_is_div_s = (bus.i_op == 2'd1) || (bus.i_op == 2'd2);
  assign last_s       = (cnt_r == 5'd31);
  // Next dividend bit shifts from the top of quo_r into the remainder.
  assign rem_shift_s  = {rem_r[30:0], quo_r[31]};

  assign bus.o_ready  = (state_r == ST_IDLE) & ~i_reset;
  assign bus.o_valid  = valid_r;
  assign bus.o_result = result_r;
  assign bus.o_busy   = (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and the ALU operation issued in the current state.
  always_comb begin
    state_next_s = state_r;
    o_alu_op     = ALU_ADD;
    o_operand_a  = 32'd0;
    o_operand_b  = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_valid) begin
          state_next_s = req_is_div_s ? ST_DIV_CMP : ST_MUL_IT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL_IT: begin
        o_alu_op     = ALU_ADD;
        o_operand_a  = rem_r;
        o_operand_b  = quo_r[0] ? dsr_r : 32'd0;
        state_next_s = last_s ? ST_DONE : ST_MUL_IT;
      end
      ST_DIV_CMP: begin
        o_alu_op     = ALU_SLTU;
        o_operand_a  = rem_shift_s;
        o_operand_b  = dsr_r;
        state_next_s = ST_DIV_SUB;
      end
      ST_DIV_SUB: begin
        o_alu_op     = ALU_SUB;
        o_operand_a  = rem_r;
        o_operand_b  = dsr_r;
        state_next_s = last_s ? ST_DONE : ST_DIV_CMP;
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath registers and the registered result/valid outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rem_r    <= 32'd0;
      dsr_r    <= 32'd0;
      quo_r    <= 32'd0;
      cnt_r    <= 5'd0;
      op_r     <= 2'd0;
      lt_r     <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_valid) begin
            op_r  <= bus.i_op;
            rem_r <= 32'd0;
            cnt_r <= 5'd0;
            lt_r  <= 1'b0;
            dsr_r <= req_is_div_s ? bus.i_src_b : bus.i_src_a;
            quo_r <= req_is_div_s ? bus.i_src_a : bus.i_src_b;
          end
        end
        ST_MUL_IT: begin
          rem_r <= i_alu_data;
          dsr_r <= dsr_r << 1;
          quo_r <= quo_r >> 1;
          cnt_r <= cnt_r + 5'd1;
          if (last_s) begin
            result_r <= i_alu_data;
            valid_r  <= 1'b1;
          end
        end
        ST_DIV_CMP: begin
          rem_r <= rem_shift_s;
          quo_r <= quo_r << 1;
          // A set rem_r[31] means the shifted remainder is >= 2^32 > divisor,
          // so the subtract must happen regardless of the 32-bit compare.
          lt_r  <= i_alu_data[0] & ~rem_r[31];
        end
        ST_DIV_SUB: begin
          if (!lt_r) begin
            rem_r    <= i_alu_data;
            quo_r[0] <= 1'b1;
          end
          cnt_r <= cnt_r + 5'd1;
          if (last_s) begin
            valid_r <= 1'b1;
            if (op_r == 2'd2) begin
              result_r <= lt_r ? rem_r : i_alu_data;
            end else begin
              result_r <= quo_r | {31'd0, ~lt_r};
            end
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            valid_r <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
